vc_demux4_pipe: RTL and testbench
=================================

Name: vc_demux4_pipe

Overview:
- One-to-four val/rdy demultiplexer; the steering counterpart of the N-input select muxes in the vc component library.
- Routes each accepted input message to one of four output ports chosen by a 2-bit select, through a one-entry pipeline buffer per port.
- Each message carries a 1-bit security domain tag; the tag travels with the payload so every output is labelled by the domain of the data it holds.
- Sits between a shared request source (e.g. a core-side port) and four downstream consumers (memory banks, network ports).

Parameters:
- p_nbits, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input ready; a transfer occurs when in_val and in_rdy are both 1.
- in_sel  input  2  destination port index 0..3; security label L.
- in_domain  input  1  domain tag of the input message; label L.
- in_msg  input  p_nbits  payload; label Domain in_domain.
- out_val  output  4  per-port valid; bit i belongs to port i.
- out_rdy  input  4  per-port ready.
- out_domain  output  4  per-port domain tag of the buffered message.
- out_msg0..out_msg3  output  p_nbits each  per-port payload; label Domain out_domain[i].

Behaviour:
- State: per port i, a full flag f[i], a payload register m[i] and a domain register d[i].
- Outputs:
  - out_val[i] = f[i]
  - out_msg_i = m[i]
  - out_domain[i] = d[i]
  - All outputs are registered; there is no combinational path from in_msg to the outputs.
- Ready: in_rdy = ~f[in_sel] | out_rdy[in_sel]. This is combinational in in_sel and out_rdy, and is independent of in_val.
- Drain: if f[i] and out_rdy[i] at an edge, the port-i message is consumed.
- Fill: if in_val and in_rdy at an edge, m[in_sel] <= in_msg, d[in_sel] <= in_domain, f[in_sel] <= 1.
- Latency: a message accepted at edge t appears with out_val=1 from edge t onward, i.e. visible in cycle t+1. Full throughput is one message per cycle to the same port while that port's out_rdy stays 1.
- Simultaneous drain and fill on the same port in one cycle: the new message replaces the old one and f stays 1. No bubble.
- Drain on port i with fill on port j≠i: the two updates are independent.
- Drain with no fill on a port: f <= 0. m and d hold their last values; they are don't-care while out_val=0 but must not change.
- Fill refused (in_rdy=0): no state changes on any port. in_msg is ignored.
- Ordering:
  - Messages to the same port leave in acceptance order.
  - There is no ordering guarantee across ports.
  - Head-of-line blocking is intended: a full, stalled target port deasserts in_rdy even if other ports are empty.
- Domain rule: d[i] is overwritten only on fill. A port never mixes a domain-1 payload with a domain-0 tag or the reverse. Payload and tag update in the same edge.
- Reset, synchronous, active-high:
  - f <= 0, m <= 0, d <= 0 on all ports.
  - out_val = 4'b0000, out_domain = 4'b0000, all out_msg = 0 from the cycle after reset is sampled high.
  - Reset asserted mid-operation discards any buffered messages, and any input transfer in that same cycle is also discarded.
  - in_rdy during reset is combinational from the cleared state; traffic presented during reset is not kept.
- No X may propagate to out_val or in_rdy after reset, including with in_sel undriven while in_val=0. in_rdy may follow in_sel but must be 0/1 for any defined in_sel.

Test Plan:
- Reset then idle, out_rdy=4'b1111 → out_val=0000, out_domain=0000, all out_msg=0, in_rdy=1 for every in_sel.
- Send in_msg=32'hA5A5_0001, sel=2, domain=1 with port 2 idle → next cycle out_val=0100, out_msg2=A5A5_0001, out_domain[2]=1. With out_rdy[2]=1, out_val returns to 0000 one cycle later.
- Port 1: out_rdy[1]=0, send 32'h11 then 32'h22 to port 1 → first is accepted. in_rdy=0 on the second while sel=1. Raising out_rdy[1] accepts 32'h22 in that same cycle with out_val[1] staying 1, and the payloads are seen in order 11 then 22.
- Back-to-back stream 1,2,3,4 to port 3 with out_rdy[3]=1 → accepted one per cycle, out_msg3 = 1,2,3,4 on consecutive cycles, no bubbles.
- Port 0 full and stalled; send to port 0 then port 1 → in_rdy=0 for sel=0. Switching sel to 1 gives in_rdy=1 and port 1 fills while port 0 holds its value.
- Fill ports 0..3 with domains 0,1,0,1, then assert reset for one cycle → out_val=0000 and out_domain=0000 next cycle. A message offered during reset does not appear afterwards.

Source files
------------

// File: rtl/vc_demux4_pipe.sv
// vc_demux4_pipe: one-to-four val/rdy demultiplexer with a one-entry
// registered buffer per output port. Each buffered payload carries the
// security domain tag it arrived with. Payload and tag are always written
// together on the same edge.
module vc_demux4_pipe #(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [1:0]         in_sel,
    input  logic               in_domain,
    input  logic [p_nbits-1:0] in_msg,
    output logic [3:0]         out_val,
    input  logic [3:0]         out_rdy,
    output logic [3:0]         out_domain,
    output logic [p_nbits-1:0] out_msg0,
    output logic [p_nbits-1:0] out_msg1,
    output logic [p_nbits-1:0] out_msg2,
    output logic [p_nbits-1:0] out_msg3
);

    logic [3:0]         full_q;
    logic [3:0]         full_d;
    logic [3:0]         dom_q;
    logic [3:0]         dom_d;
    logic [p_nbits-1:0] msg_q [4];
    logic [p_nbits-1:0] msg_d [4];
    logic [3:0]         sel_onehot_s;
    logic               fire_s;

    // Ready for the selected port: it is empty or is draining this cycle.
    // An undefined select falls to the default so in_rdy stays a clean 0.
    always_comb begin
        in_rdy = 1'b0;
        case (in_sel)
            2'd0:    in_rdy = ~full_q[0] | out_rdy[0];
            2'd1:    in_rdy = ~full_q[1] | out_rdy[1];
            2'd2:    in_rdy = ~full_q[2] | out_rdy[2];
            2'd3:    in_rdy = ~full_q[3] | out_rdy[3];
            default: in_rdy = 1'b0;
        endcase
    end

    // One-hot decode of the destination port.
    always_comb begin
        sel_onehot_s = 4'b0000;
        case (in_sel)
            2'd0:    sel_onehot_s = 4'b0001;
            2'd1:    sel_onehot_s = 4'b0010;
            2'd2:    sel_onehot_s = 4'b0100;
            2'd3:    sel_onehot_s = 4'b1000;
            default: sel_onehot_s = 4'b0000;
        endcase
    end

    assign fire_s = in_val & in_rdy;

    // Per-port next state. A fill wins over a drain, which gives the
    // bubble-free replace. A drain alone only clears the full flag, so the
    // payload and tag hold their last values.
    always_comb begin
        full_d = full_q;
        dom_d  = dom_q;
        for (int i = 0; i < 4; i++) begin
            msg_d[i] = msg_q[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (fire_s && sel_onehot_s[i]) begin
                full_d[i] = 1'b1;
                msg_d[i]  = in_msg;
                dom_d[i]  = in_domain;
            end else if (full_q[i] && out_rdy[i]) begin
                full_d[i] = 1'b0;
            end else begin
                full_d[i] = full_q[i];
            end
        end
    end

    // State registers. Reset discards buffered data and any same-cycle fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 4'b0000;
            dom_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                msg_q[i] <= {p_nbits{1'b0}};
            end
        end else begin
            full_q <= full_d;
            dom_q  <= dom_d;
            for (int i = 0; i < 4; i++) begin
                msg_q[i] <= msg_d[i];
            end
        end
    end

    assign out_val    = full_q;
    assign out_domain = dom_q;
    assign out_msg0   = msg_q[0];
    assign out_msg1   = msg_q[1];
    assign out_msg2   = msg_q[2];
    assign out_msg3   = msg_q[3];

endmodule

// File: tb/tb_vc_demux4_pipe.sv
// Self-checking bench for vc_demux4_pipe: directed scenarios followed by
// random traffic. The reference keeps one FIFO per port (capacity one) plus
// the last written payload/tag per port.
module tb_vc_demux4_pipe;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [1:0]  in_sel;
    logic        in_domain;
    logic [31:0] in_msg;
    logic [3:0]  out_val;
    logic [3:0]  out_rdy;
    logic [3:0]  out_domain;
    logic [31:0] out_msg0;
    logic [31:0] out_msg1;
    logic [31:0] out_msg2;
    logic [31:0] out_msg3;

    int vectors;
    int miscompares;

    // reference model
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    logic [32:0] q3[$];
    logic [31:0] last_msg [4];
    logic        last_dom [4];

    vc_demux4_pipe #(.p_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel),
        .in_domain(in_domain), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_domain(out_domain),
        .out_msg0(out_msg0), .out_msg1(out_msg1),
        .out_msg2(out_msg2), .out_msg3(out_msg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [31:0] dut_msg(input int p);
        case (p)
            0:       return out_msg0;
            1:       return out_msg1;
            2:       return out_msg2;
            default: return out_msg3;
        endcase
    endfunction

    // the port can take a message if its FIFO has room after this cycle's drain
    function automatic logic model_rdy(input int p);
        return (qsize(p) == 0) || (out_rdy[p] == 1'b1);
    endfunction

    task automatic model_edge();
        logic fire;
        int   s;
        if (reset) begin
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
            for (int i = 0; i < 4; i++) begin
                last_msg[i] = 32'h0;
                last_dom[i] = 1'b0;
            end
        end else begin
            s    = int'(in_sel);
            fire = in_val && model_rdy(s);
            if (q0.size() > 0 && out_rdy[0]) void'(q0.pop_front());
            if (q1.size() > 0 && out_rdy[1]) void'(q1.pop_front());
            if (q2.size() > 0 && out_rdy[2]) void'(q2.pop_front());
            if (q3.size() > 0 && out_rdy[3]) void'(q3.pop_front());
            if (fire) begin
                case (s)
                    0:       q0.push_back({in_domain, in_msg});
                    1:       q1.push_back({in_domain, in_msg});
                    2:       q2.push_back({in_domain, in_msg});
                    default: q3.push_back({in_domain, in_msg});
                endcase
                last_msg[s] = in_msg;
                last_dom[s] = in_domain;
            end
        end
    endtask

    // One clock: compare DUT against model just before the edge, then
    // advance the model on the edge and return at the following negedge.
    task automatic cycle();
        logic [3:0] ev;
        logic [3:0] ed;
        while (($time % 10) != 4) #1;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (qsize(i) > 0);
            ed[i] = last_dom[i];
        end
        chk("in_rdy", {63'h0, in_rdy}, {63'h0, model_rdy(int'(in_sel))});
        chk("out_val", {60'h0, out_val}, {60'h0, ev});
        chk("out_domain", {60'h0, out_domain}, {60'h0, ed});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_msg%0d", i), {32'h0, dut_msg(i)}, {32'h0, last_msg[i]});
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        in_val    = 1'b0;
        in_sel    = 2'd0;
        in_domain = 1'b0;
        in_msg    = 32'h0;
        out_rdy   = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_edge();
        cycle();
        reset = 1'b0;
        cycle();

        // reset then idle: empty outputs, ready for every select
        chk("rst_val", {60'h0, out_val}, 64'h0);
        chk("rst_dom", {60'h0, out_domain}, 64'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst_rdy_sel%0d", s), {63'h0, in_rdy}, 64'h1);
        end

        // single message to port 2, domain 1
        in_val = 1'b1; in_sel = 2'd2; in_domain = 1'b1; in_msg = 32'hA5A5_0001;
        cycle();
        in_val = 1'b0;
        chk("p2_val", {60'h0, out_val}, 64'h4);
        chk("p2_msg", {32'h0, out_msg2}, 64'hA5A5_0001);
        chk("p2_dom", {63'h0, out_domain[2]}, 64'h1);
        cycle();
        chk("p2_drained", {60'h0, out_val}, 64'h0);

        // port 1 stalled: second message refused until out_rdy[1] rises
        out_rdy = 4'b1101;
        in_val = 1'b1; in_sel = 2'd1; in_domain = 1'b0; in_msg = 32'h11;
        cycle();
        chk("p1_first", {32'h0, out_msg1}, 64'h11);
        in_msg = 32'h22;
        #1;
        chk("p1_block_rdy", {63'h0, in_rdy}, 64'h0);
        cycle();
        chk("p1_hold", {32'h0, out_msg1}, 64'h11);
        out_rdy = 4'b1111;
        #1;
        chk("p1_unblock_rdy", {63'h0, in_rdy}, 64'h1);
        cycle();
        in_val = 1'b0;
        chk("p1_val_stays", {63'h0, out_val[1]}, 64'h1);
        chk("p1_second", {32'h0, out_msg1}, 64'h22);
        cycle();

        // back-to-back stream to port 3
        in_val = 1'b1; in_sel = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            in_msg = 32'(k);
            in_domain = 1'(k);
            cycle();
            chk($sformatf("p3_stream%0d_val", k), {63'h0, out_val[3]}, 64'h1);
            chk($sformatf("p3_stream%0d_msg", k), {32'h0, out_msg3}, 64'(k));
        end
        in_val = 1'b0;
        cycle();
        chk("p3_idle", {60'h0, out_val}, 64'h0);

        // head-of-line: port 0 stalled, port 1 still reachable
        out_rdy = 4'b1110;
        in_val = 1'b1; in_sel = 2'd0; in_domain = 1'b1; in_msg = 32'h50;
        cycle();
        in_msg = 32'h51;
        #1;
        chk("hol_rdy0", {63'h0, in_rdy}, 64'h0);
        cycle();
        in_sel = 2'd1; in_domain = 1'b0; in_msg = 32'h61;
        #1;
        chk("hol_rdy1", {63'h0, in_rdy}, 64'h1);
        cycle();
        in_val = 1'b0;
        chk("hol_val", {60'h0, out_val}, 64'h3);
        chk("hol_p0", {32'h0, out_msg0}, 64'h50);
        chk("hol_p1", {32'h0, out_msg1}, 64'h61);
        out_rdy = 4'b1111;
        cycle();
        cycle();

        // fill every port, then reset with a message on offer
        out_rdy = 4'b0000;
        in_val = 1'b1;
        for (int p = 0; p < 4; p++) begin
            in_sel = 2'(p); in_domain = 1'(p); in_msg = 32'h100 + 32'(p);
            cycle();
        end
        chk("fill_val", {60'h0, out_val}, 64'hF);
        chk("fill_dom", {60'h0, out_domain}, 64'hA);
        reset = 1'b1; in_sel = 2'd2; in_domain = 1'b1; in_msg = 32'hDEAD_BEEF;
        out_rdy = 4'b1111;
        cycle();
        reset = 1'b0; in_val = 1'b0;
        chk("mid_rst_val", {60'h0, out_val}, 64'h0);
        chk("mid_rst_dom", {60'h0, out_domain}, 64'h0);
        chk("mid_rst_msg2", {32'h0, out_msg2}, 64'h0);
        cycle();
        chk("mid_rst_after", {60'h0, out_val}, 64'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(63) == 0);
            in_val    = 1'($urandom_range(1));
            in_sel    = 2'($urandom_range(3));
            in_domain = 1'($urandom_range(1));
            in_msg    = $urandom;
            out_rdy   = 4'($urandom_range(15));
            cycle();
        end
        reset = 1'b0; in_val = 1'b0; out_rdy = 4'b1111;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
